// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_pkg : shared widths, FSM encoding and parity helper for dmem   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package dmem_pkg;
  localparam int WORD_W     = 16;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Even parity bit: makes the total count of ones in {bit, data} even
  function automatic logic even_parity(input logic [WORD_W-1:0] data);
    return ^data;
  endfunction
endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_if : req/ack word load/store bus between core and data memory  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ack;
  logic [WORD_W-1:0] rdata;
  logic              busy;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);
endinterface
`default_nettype wire

// File: rtl/dmem_wait_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_wait_counter : loadable wait-state down-counter with done flag |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dmem_wait_counter
  import dmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  done
);
  logic [WAIT_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A zero load means no wait states, so the accept cycle itself is the last one
  assign done = load ? (load_val == '0) : (r_count == WAIT_CNT_W'(1));
endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_responder : wait-stated word RAM slave; optional parity via    |
// | DMEM_PARITY_EN.                                           Rev 1.0   |
// +--------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
`ifdef DMEM_PARITY_EN
  localparam int c_mem_w = WORD_W + 1;
`else
  localparam int c_mem_w = WORD_W;
`endif
  localparam logic [WAIT_CNT_W-1:0] c_wait_load = WAIT_CNT_W'(WAIT_CYCLES);

  if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > (2**WAIT_CNT_W) - 1)) begin : g_wait_range_check
    $error("dmem_responder: WAIT_CYCLES out of range 0..15");
  end

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [WORD_W-1:0]  r_wdata;
  logic [WORD_W-1:0]  r_rdata;
  logic               w_load;
  logic               w_dec;
  logic               w_done;
  logic               w_accept;
  logic               w_enter_resp;
  logic               w_is_load;
  logic [ADDR_W-1:0]  w_addr;
  logic [c_mem_w-1:0] w_rd_word;
  logic [c_mem_w-1:0] w_wr_word;
  logic [c_mem_w-1:0] r_mem [0:(2**ADDR_W)-1];

  dmem_wait_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (c_wait_load),
    .dec      (w_dec),
    .done     (w_done)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_load = 1'b1;
          w_next = w_done ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_dec = 1'b1;
        if (w_done) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Load data is read on the edge entering RESP so it lines up with ack;
  // with zero wait states that edge is the accept edge, hence the bypass.
  assign w_accept     = (r_state == IDLE) && bus.req;
  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
  assign w_is_load    = w_accept ? !bus.we : !r_we;
  assign w_addr       = w_accept ? bus.addr : r_addr;
  assign w_rd_word    = r_mem[w_addr];

`ifdef DMEM_PARITY_EN
  logic r_err;
  assign w_wr_word = {even_parity(r_wdata), r_wdata};
`else
  assign w_wr_word = r_wdata;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef DMEM_PARITY_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (w_enter_resp && w_is_load) begin
        r_rdata <= w_rd_word[WORD_W-1:0];
      end
`ifdef DMEM_PARITY_EN
      r_err <= w_enter_resp && w_is_load && (^w_rd_word);
`endif
    end
  end

  // RAM has no reset; an aborted access never reaches RESP, so nothing is written
  always_ff @(posedge clk) begin
    if ((r_state == RESP) && r_we) begin
      r_mem[r_addr] <= w_wr_word;
    end
  end

  assign bus.ack   = (r_state == RESP);
  assign bus.busy  = (r_state != IDLE);
  assign bus.rdata = r_rdata;
`ifdef DMEM_PARITY_EN
  assign bus.err   = r_err;
`else
  assign bus.err   = 1'b0;
`endif
endmodule
`default_nettype wire
